// File: rtl/alarm_ring_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_ctrl_pkg
// Description : Shared state encoding, BCD MM:SS field layout and the
//               BCD digit check used by the alarm ring controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_ring_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_e;

    localparam logic [3:0] c_BCD_MAX      = 4'd9;
    localparam int         c_SEC_ONES_LSB = 0;
    localparam int         c_SEC_TENS_LSB = 4;
    localparam int         c_MIN_ONES_LSB = 8;
    localparam int         c_MIN_TENS_LSB = 12;

    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[c_SEC_ONES_LSB +: 4] <= c_BCD_MAX) &&
               (v[c_SEC_TENS_LSB +: 4] <= c_BCD_MAX) &&
               (v[c_MIN_ONES_LSB +: 4] <= c_BCD_MAX) &&
               (v[c_MIN_TENS_LSB +: 4] <= c_BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ring_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_ctrl_if
// Description : Alarm value, timekeeping, button and ring/display signals
//               between the alarm ring controller and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_ring_ctrl_if;
    logic [15:0] alarm;
    logic        alarm_valid;
    logic [15:0] cur_time;
    logic        sec_tick;
    logic        push_u;
    logic        push_c;
    logic        ring;
    logic        blink;
    logic        missed;
    logic        bad_alarm;
    logic [1:0]  state;
    logic [1:0]  snooze_used;

    modport master (
        output alarm, alarm_valid, cur_time, sec_tick, push_u, push_c,
        input  ring, blink, missed, bad_alarm, state, snooze_used
    );

    modport slave (
        input  alarm, alarm_valid, cur_time, sec_tick, push_u, push_c,
        output ring, blink, missed, bad_alarm, state, snooze_used
    );
endinterface
`default_nettype wire

// File: rtl/alarm_ring_ctrl_sec_counter.sv
`default_nettype none
// ============================================================================
// Module      : alarm_sec_counter
// Description : 8-bit seconds counter, load or decrement-on-tick, with a
//               done strobe on the tick that consumes the last second.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_sec_counter (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_load_val,
    input  wire logic       i_tick,
    output logic            o_done
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = i_tick && !i_load && (cnt_q == 8'd1);

endmodule
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_ctrl
// Description : Arms on a valid BCD alarm, rings on a per-second match,
//               handles dismiss, auto-timeout and (ALARM_SNOOZE_EN) snooze.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    alarm_ring_ctrl_if.slave  bus
);

    if ((RING_SEC < 1) || (RING_SEC > 255) || (SNOOZE_SEC < 1) ||
        (SNOOZE_SEC > 255) || (MAX_SNOOZE < 0) || (MAX_SNOOZE > 3)) begin : g_param_check
        $error("alarm_ring_ctrl: parameter out of range");
    end

    localparam logic [7:0] c_RING_LOAD = 8'(RING_SEC);

    state_e      state_q, state_d;
    logic [15:0] alarm_q, alarm_d;
    logic        ring_q, ring_d;
    logic        blink_q, blink_d;
    logic        missed_q, missed_d;
    logic        bad_alarm_q, bad_alarm_d;

    logic        w_match;
    logic        w_ring_load;
    logic        w_ring_done;
    logic        w_to_armed;

    assign w_match = bus.sec_tick && (bus.cur_time == alarm_q);

    alarm_sec_counter u_ring_cnt (
        .clk        (clk),
        .rst        (resetn),
        .i_load     (w_ring_load),
        .i_load_val (c_RING_LOAD),
        .i_tick     (bus.sec_tick),
        .o_done     (w_ring_done)
    );

`ifdef ALARM_SNOOZE_EN
    localparam logic [7:0] c_SNZ_LOAD   = 8'(SNOOZE_SEC);
    localparam logic [1:0] c_MAX_SNOOZE = 2'(MAX_SNOOZE);

    logic [1:0] snooze_used_q, snooze_used_d;
    logic       w_snz_load;
    logic       w_snz_done;

    alarm_sec_counter u_snz_cnt (
        .clk        (clk),
        .rst        (resetn),
        .i_load     (w_snz_load),
        .i_load_val (c_SNZ_LOAD),
        .i_tick     (bus.sec_tick),
        .o_done     (w_snz_done)
    );
`endif

    always_comb begin
        state_d     = state_q;
        alarm_d     = alarm_q;
        ring_d      = ring_q;
        blink_d     = blink_q;
        missed_d    = missed_q;
        bad_alarm_d = bad_alarm_q;
        w_ring_load = 1'b0;
        w_to_armed  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snooze_used_d = snooze_used_q;
        w_snz_load    = 1'b0;
`endif

        // Dismiss always acknowledges a missed alarm, whatever else happens.
        if (bus.push_c) begin
            missed_d = 1'b0;
        end

        if (!bus.alarm_valid) begin
            state_d = ST_IDLE;
            ring_d  = 1'b0;
            blink_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_used_d = 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bcd_valid(bus.alarm)) begin
                        alarm_d     = bus.alarm;
                        bad_alarm_d = 1'b0;
                        missed_d    = 1'b0;
                        w_to_armed  = 1'b1;
                    end else begin
                        bad_alarm_d = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!bus.push_c && w_match) begin
                        state_d     = ST_RINGING;
                        ring_d      = 1'b1;
                        blink_d     = 1'b1;
                        w_ring_load = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (bus.push_c) begin
                        w_to_armed = 1'b1;
                    end else if (w_ring_done) begin
                        w_to_armed = 1'b1;
                        missed_d   = 1'b1;
                    end else begin
                        if (bus.sec_tick) begin
                            blink_d = ~blink_q;
                        end
`ifdef ALARM_SNOOZE_EN
                        if (bus.push_u && (snooze_used_q < c_MAX_SNOOZE)) begin
                            state_d       = ST_SNOOZE;
                            ring_d        = 1'b0;
                            blink_d       = 1'b0;
                            snooze_used_d = snooze_used_q + 2'd1;
                            w_snz_load    = 1'b1;
                        end
`endif
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (bus.push_c) begin
                        w_to_armed = 1'b1;
                    end else if (w_snz_done) begin
                        state_d     = ST_RINGING;
                        ring_d      = 1'b1;
                        blink_d     = 1'b1;
                        w_ring_load = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    ring_d  = 1'b0;
                    blink_d = 1'b0;
                end
            endcase

            if (w_to_armed) begin
                state_d = ST_ARMED;
                ring_d  = 1'b0;
                blink_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
                snooze_used_d = 2'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= ST_IDLE;
            alarm_q     <= 16'h0000;
            ring_q      <= 1'b0;
            blink_q     <= 1'b0;
            missed_q    <= 1'b0;
            bad_alarm_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_used_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            ring_q      <= ring_d;
            blink_q     <= blink_d;
            missed_q    <= missed_d;
            bad_alarm_q <= bad_alarm_d;
`ifdef ALARM_SNOOZE_EN
            snooze_used_q <= snooze_used_d;
`endif
        end
    end

    assign bus.ring      = ring_q;
    assign bus.blink     = blink_q;
    assign bus.missed    = missed_q;
    assign bus.bad_alarm = bad_alarm_q;
    assign bus.state     = state_q;
`ifdef ALARM_SNOOZE_EN
    assign bus.snooze_used = snooze_used_q;
`else
    assign bus.snooze_used = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ring_ctrl
// Description : Directed scenarios plus randomized stimulus against a
//               behavioural model of the alarm ring controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;

    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 2;
    localparam int MAX_SNOOZE = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNOOZE = 3;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;

    alarm_ring_ctrl_if bus ();

    alarm_ring_ctrl #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: seconds rung counted up, snooze seconds counted down.
    int          m_state = S_IDLE;
    bit          m_ring = 0, m_blink = 0, m_missed = 0, m_bad = 0;
    logic [15:0] m_alarm = 16'h0000;
    int          m_elapsed = 0, m_snz_left = 0, m_used = 0;

    function automatic bit digits_ok(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 16'h000F) > 16'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_dismiss();
        m_state = S_ARMED;
        m_ring  = 0;
        m_blink = 0;
        m_used  = 0;
    endtask

    task automatic m_start_ring();
        m_state   = S_RING;
        m_ring    = 1;
        m_blink   = 1;
        m_elapsed = 0;
    endtask

    task automatic model_step();
        if (resetn) begin
            m_state = S_IDLE; m_ring = 0; m_blink = 0; m_missed = 0; m_bad = 0;
            m_alarm = 16'h0000; m_elapsed = 0; m_snz_left = 0; m_used = 0;
            return;
        end
        if (bus.push_c) m_missed = 0;
        if (!bus.alarm_valid) begin
            m_state = S_IDLE; m_ring = 0; m_blink = 0; m_used = 0;
            return;
        end
        case (m_state)
            S_IDLE: begin
                if (digits_ok(bus.alarm)) begin
                    m_alarm = bus.alarm; m_bad = 0; m_missed = 0;
                    m_dismiss();
                end else begin
                    m_bad = 1;
                end
            end
            S_ARMED: begin
                if (!bus.push_c && bus.sec_tick && bus.cur_time == m_alarm) m_start_ring();
            end
            S_RING: begin
                if (bus.push_c) begin
                    m_dismiss();
                end else if (bus.sec_tick && m_elapsed == RING_SEC - 1) begin
                    m_dismiss();
                    m_missed = 1;
                end else if (SNZ_EN && bus.push_u && m_used < MAX_SNOOZE) begin
                    m_state = S_SNOOZE; m_ring = 0; m_blink = 0;
                    m_snz_left = SNOOZE_SEC; m_used = m_used + 1;
                end else if (bus.sec_tick) begin
                    m_blink = !m_blink;
                    m_elapsed = m_elapsed + 1;
                end
            end
            default: begin
                if (bus.push_c) begin
                    m_dismiss();
                end else if (bus.sec_tick) begin
                    if (m_snz_left == 1) m_start_ring();
                    else m_snz_left = m_snz_left - 1;
                end
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input logic [15:0] t);
        bus.cur_time = t;
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        step(2);
        checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", bus.state); end
        checks++; if ({bus.ring, bus.blink, bus.missed, bus.bad_alarm} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", {bus.ring, bus.blink, bus.missed, bus.bad_alarm}); end
        checks++; if (bus.snooze_used !== 2'd0) begin failures++; $display("FAIL reset_snooze_used got=%0d want=0", bus.snooze_used); end
        resetn = 1'b0;
        step(1);
    endtask

    task automatic test_arm_and_match();
        bus.alarm = 16'h0105; bus.alarm_valid = 1'b1; bus.cur_time = 16'h0103;
        step(1);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL arm_state got=%0d want=1", bus.state); end
        bus.alarm = 16'h0104;
        do_tick(16'h0103); step(2);
        do_tick(16'h0104); step(2);
        checks++; if (bus.ring !== 1'b0) begin failures++; $display("FAIL arm_ignores_new_alarm ring got=%b want=0", bus.ring); end
        bus.alarm = 16'h0105;
        do_tick(16'h0105);
        checks++; if ({bus.state, bus.ring, bus.blink} !== {2'd2, 1'b1, 1'b1}) begin failures++; $display("FAIL match_ring got state=%0d ring=%b blink=%b want 2 1 1", bus.state, bus.ring, bus.blink); end
        step(2);
        do_tick(16'h0106);
        checks++; if ({bus.ring, bus.blink} !== 2'b10) begin failures++; $display("FAIL blink_toggle1 got ring=%b blink=%b want 1 0", bus.ring, bus.blink); end
    endtask

    task automatic test_timeout();
        step(2);
        do_tick(16'h0107);
        checks++; if ({bus.ring, bus.blink} !== 2'b11) begin failures++; $display("FAIL blink_toggle2 got ring=%b blink=%b want 1 1", bus.ring, bus.blink); end
        step(2);
        do_tick(16'h0108);
        checks++; if ({bus.state, bus.ring, bus.missed} !== {2'd1, 1'b0, 1'b1}) begin failures++; $display("FAIL timeout got state=%0d ring=%b missed=%b want 1 0 1", bus.state, bus.ring, bus.missed); end
        bus.push_c = 1'b1; step(1); bus.push_c = 1'b0;
        checks++; if ({bus.state, bus.missed} !== {2'd1, 1'b0}) begin failures++; $display("FAIL missed_clear got state=%0d missed=%b want 1 0", bus.state, bus.missed); end
    endtask

    task automatic test_snooze();
        do_tick(16'h0105);
        step(1);
        bus.push_u = 1'b1; step(1); bus.push_u = 1'b0;
        if (SNZ_EN) begin
            checks++; if ({bus.state, bus.snooze_used, bus.ring} !== {2'd3, 2'd1, 1'b0}) begin failures++; $display("FAIL snooze_enter got state=%0d used=%0d ring=%b want 3 1 0", bus.state, bus.snooze_used, bus.ring); end
            do_tick(16'h0110);
            checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL snooze_hold got=%0d want=3", bus.state); end
            do_tick(16'h0111);
            checks++; if ({bus.state, bus.ring} !== {2'd2, 1'b1}) begin failures++; $display("FAIL snooze_rering got state=%0d ring=%b want 2 1", bus.state, bus.ring); end
            bus.push_u = 1'b1; step(1); bus.push_u = 1'b0;
            checks++; if ({bus.state, bus.snooze_used} !== {2'd2, 2'd1}) begin failures++; $display("FAIL snooze_limit got state=%0d used=%0d want 2 1", bus.state, bus.snooze_used); end
        end else begin
            checks++; if ({bus.state, bus.snooze_used, bus.ring} !== {2'd2, 2'd0, 1'b1}) begin failures++; $display("FAIL snooze_disabled got state=%0d used=%0d ring=%b want 2 0 1", bus.state, bus.snooze_used, bus.ring); end
        end
        bus.push_c = 1'b1; step(1); bus.push_c = 1'b0;
        checks++; if ({bus.state, bus.snooze_used, bus.ring} !== {2'd1, 2'd0, 1'b0}) begin failures++; $display("FAIL snooze_dismiss got state=%0d used=%0d ring=%b want 1 0 0", bus.state, bus.snooze_used, bus.ring); end
    endtask

    task automatic test_simultaneous();
        do_tick(16'h0105); step(1);
        do_tick(16'h0106); step(1);
        do_tick(16'h0107); step(1);
        bus.push_c = 1'b1;
        do_tick(16'h0108);
        bus.push_c = 1'b0;
        checks++; if ({bus.state, bus.ring, bus.missed} !== {2'd1, 1'b0, 1'b0}) begin failures++; $display("FAIL dismiss_beats_timeout got state=%0d ring=%b missed=%b want 1 0 0", bus.state, bus.ring, bus.missed); end
        do_tick(16'h0105);
        bus.alarm_valid = 1'b0;
        step(1);
        checks++; if ({bus.state, bus.ring, bus.blink} !== {2'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL valid_drop got state=%0d ring=%b blink=%b want 0 0 0", bus.state, bus.ring, bus.blink); end
    endtask

    task automatic test_bad_alarm();
        bus.alarm = 16'h0A00; bus.alarm_valid = 1'b1;
        step(1);
        checks++; if ({bus.state, bus.bad_alarm} !== {2'd0, 1'b1}) begin failures++; $display("FAIL bad_alarm got state=%0d bad=%b want 0 1", bus.state, bus.bad_alarm); end
        bus.alarm = 16'h0100;
        step(1);
        checks++; if ({bus.state, bus.bad_alarm} !== {2'd1, 1'b0}) begin failures++; $display("FAIL good_alarm got state=%0d bad=%b want 1 0", bus.state, bus.bad_alarm); end
    endtask

    task automatic test_reset_mid_ring();
        do_tick(16'h0100);
        checks++; if (bus.ring !== 1'b1) begin failures++; $display("FAIL mid_ring_start got ring=%b want 1", bus.ring); end
        resetn = 1'b1; step(1); resetn = 1'b0;
        checks++; if ({bus.state, bus.ring, bus.blink, bus.missed, bus.bad_alarm, bus.snooze_used} !== 8'd0) begin failures++; $display("FAIL mid_ring_reset got state=%0d ring=%b blink=%b missed=%b bad=%b used=%0d want all 0", bus.state, bus.ring, bus.blink, bus.missed, bus.bad_alarm, bus.snooze_used); end
        step(1);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL rearm_after_reset got=%0d want=1", bus.state); end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int c = 0; c < 3000; c++) begin
            resetn          = ($urandom_range(0, 199) == 0);
            bus.alarm_valid = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) bus.alarm = 16'($urandom_range(0, 65535));
            else bus.alarm = 16'h0100 + 16'($urandom_range(0, 1));
            bus.cur_time = 16'h0100 + 16'($urandom_range(0, 1));
            bus.sec_tick = ($urandom_range(0, 2) == 0);
            bus.push_c   = ($urandom_range(0, 29) == 0);
            bus.push_u   = ($urandom_range(0, 9) == 0);
            step(1);
            checks++;
            if ({bus.ring, bus.blink, bus.missed, bus.bad_alarm, bus.state, bus.snooze_used} !==
                {m_ring, m_blink, m_missed, m_bad, 2'(m_state), 2'(m_used)}) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got ring=%b blink=%b missed=%b bad=%b state=%0d used=%0d want %b %b %b %b %0d %0d",
                             c, bus.ring, bus.blink, bus.missed, bus.bad_alarm, bus.state, bus.snooze_used,
                             m_ring, m_blink, m_missed, m_bad, m_state, m_used);
                end
            end
        end
        resetn = 1'b0; bus.push_c = 1'b0; bus.push_u = 1'b0; bus.sec_tick = 1'b0;
        step(1);
    endtask

    initial begin
        resetn          = 1'b1;
        bus.alarm       = 16'h0000;
        bus.alarm_valid = 1'b0;
        bus.cur_time    = 16'h0000;
        bus.sec_tick    = 1'b0;
        bus.push_u      = 1'b0;
        bus.push_c      = 1'b0;
        test_reset();
        test_arm_and_match();
        test_timeout();
        test_snooze();
        test_simultaneous();
        test_bad_alarm();
        test_reset_mid_ring();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Consumer of the BCD alarm value (MM:SS) produced by the alarm-set service.
- Snapshots the alarm once setting is finished, compares it with the running clock every second, and raises the ring/blink outputs on a match.
- Handles dismiss, snooze and auto-timeout.
- Sits between the alarm-set service, the timekeeping counter and the LED/buzzer/display drivers.

Parameters:
- RING_SEC, 30, seconds the alarm rings before auto-timeout (1..255).
- SNOOZE_SEC, 60, snooze duration in seconds (1..255).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-high (port keeps the codebase name; asserted = 1).
- alarm  in  16  BCD MM:SS, [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- alarm_valid  in  1  level; high = alarm setting finished (setter's finish flag).
- cur_time  in  16  running clock, BCD MM:SS, same layout; valid in the sec_tick cycle.
- sec_tick  in  1  one-cycle pulse per second, coincident with the new cur_time.
- push_u  in  1  snooze request, one-cycle debounced pulse.
- push_c  in  1  dismiss, one-cycle debounced pulse.
- ring  out  1  high while ringing.
- blink  out  1  toggles each second while ringing, otherwise 0.
- missed  out  1  sticky; set on auto-timeout.
- bad_alarm  out  1  alarm rejected for a non-BCD digit.
- state  out  2  current FSM state.
- snooze_used  out  2  snoozes consumed in the current event.

Behaviour:
- All outputs are registered; every response appears the cycle after its cause.
- Reset values: ring=0, blink=0, missed=0, bad_alarm=0, state=IDLE, snooze_used=0; internal counters and alarm_q = 0.
- State encoding: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- Priority, highest first:
  1. resetn.
  2. alarm_valid low → IDLE from any state; ring=0, blink=0, snooze_used=0.
  3. push_c.
  4. Timer expiry.
  5. push_u.
- IDLE → ARMED when alarm_valid=1 and every nibble of alarm ≤ 9:
  - capture alarm into alarm_q; later alarm changes are ignored until the FSM returns to IDLE;
  - clear bad_alarm.
  - If any nibble > 9: stay in IDLE, set bad_alarm=1.
- ARMED → RINGING only in a sec_tick cycle with cur_time == alarm_q:
  - ring=1, blink=1, ring_cnt=0.
  - The compare is never evaluated outside sec_tick, so one match per second; no double-fire.
- RINGING:
  - on each sec_tick: blink toggles, ring_cnt+1;
  - sec_tick with ring_cnt == RING_SEC-1 → ARMED, missed=1;
  - push_c → ARMED, missed not set; push_c in the same cycle as timeout: dismiss wins;
  - push_u with snooze_used < MAX_SNOOZE → SNOOZE: snz_cnt=SNOOZE_SEC, snooze_used+1, ring=0, blink=0;
  - push_u with snooze_used == MAX_SNOOZE: ignored.
- SNOOZE:
  - snz_cnt decrements on sec_tick; sec_tick with snz_cnt==1 → RINGING with ring_cnt=0;
  - push_c → ARMED; push_u ignored.
- Any entry into ARMED clears snooze_used. ARMED re-fires on the next hourly match.
- missed clears on push_c in any state, or on IDLE → ARMED.
- Counters are 8-bit and saturate-free within the parameter range.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: snooze behaviour as above.
- Undefined: push_u ignored, SNOOZE state unreachable, snooze_used tied to 0, no snooze counter logic. Ring, dismiss and timeout are unchanged.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/ARMED/RINGING/SNOOZE;
  - BCD digit max (9) and MM:SS nibble-field offsets, shared with the alarm-set service;
  - a BCD-valid check function.
- One natural sub-module: alarm_sec_counter, an 8-bit load/decrement-on-tick counter with a done flag. Instantiate it twice (ring timeout, snooze); the snooze instance sits under ALARM_SNOOZE_EN.

Test Plan:
- Arm and match: alarm=16'h0105, alarm_valid=1, cur_time stepped 01:03 → 01:05 on sec_ticks → state=ARMED after 1 cycle; ring=1 the cycle after the 01:05 tick; blink toggles on each later tick.
- Timeout: RING_SEC=3, no buttons → ring drops and missed=1 after the 3rd tick (ring_cnt reaches 2) following ring start; state=ARMED; push_c clears missed.
- Snooze: SNOOZE_SEC=2, MAX_SNOOZE=1; push_u while ringing → state=SNOOZE, snooze_used=1; after 2 ticks back in RINGING; a second push_u is ignored; push_c → ARMED, snooze_used=0.
- Bad alarm: alarm=16'h0A00, alarm_valid=1 → stays in IDLE, bad_alarm=1; then alarm=16'h0100 → ARMED, bad_alarm=0.
- Simultaneous events: push_c on the same cycle as the timeout tick → ARMED with missed=0. Dropping alarm_valid while ringing → IDLE with ring=0 the next cycle.
- Reset mid-ring: resetn=1 for one cycle while in RINGING → every output at its reset value the next cycle; with alarm_valid=1, ARMED again one cycle later.
